reciprocal_arbiter: RTL and testbench

- Shares one full_reciprocal core between N_REQ requesters using round-robin arbitration.
- Accepts 16-bit integer operands over per-requester valid/ready handshakes and sequences the core's start/ready protocol.
- Returns the 5.19 fixed-point reciprocal on one shared response bus, tagged with the requester ID.
- Short-circuits divide-by-zero and guards against a hung core with a watchdog.

---
 rtl/reciprocal_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/reciprocal_arbiter.sv | 138 +++++++++++++
 tb/tb_reciprocal_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reciprocal_pkg.sv
// Shared widths, FSM encoding and saturation constant for the reciprocal arbiter slice.
package reciprocal_pkg;

    localparam int unsigned IN_W   = 16;
    localparam int unsigned OUT_W  = 24;
    localparam int unsigned FRAC_W = 19;

    localparam logic [OUT_W-1:0] RECIP_SAT = 24'hFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first asserted request after last_grant wins, with wrap-around.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        // k = N revisits last_grant itself, so a lone repeat requester still wins
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_grant) + k) % N;
            if (!grant_vld && req[cand[IDX_W-1:0]]) begin
                grant_vld                = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reciprocal_arbiter.sv
// Round-robin front end sharing one reciprocal core between N_REQ requesters,
// with divide-by-zero short-circuit and a watchdog on the core handshake.
module reciprocal_arbiter #(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned IN_W    = 16,
    parameter  int unsigned OUT_W   = 24,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W    = $clog2(N_REQ),
    localparam int unsigned CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IN_W-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [OUT_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  core_start,
    output logic [IN_W-1:0]       core_in,
    input  logic                  core_ready,
    input  logic [OUT_W-1:0]      core_out,
    output logic                  busy
);

    import reciprocal_pkg::*;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [IN_W-1:0]    core_in_q, core_in_d;
    logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic [IN_W-1:0]    req_op [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_op[g] = req_data[g*IN_W +: IN_W];
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        core_in_d    = core_in_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        core_start   = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                // rst_n gate keeps req_ready low while reset is held
                if (grant_vld && rst_n) begin
                    req_ready    = grant;
                    last_grant_d = grant_idx;
                    rsp_id_d     = grant_idx;
                    core_in_d    = req_op[grant_idx];
                    if (req_op[grant_idx] == '0) begin
                        rsp_data_d = '1;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_ready) begin
                    rsp_data_d = core_out;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            rsp_id_q     <= '0;
            core_in_q    <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            core_in_q    <= core_in_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign core_in  = core_in_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reciprocal_arbiter.sv
// Directed bench for reciprocal_arbiter with a 5-cycle floor(2^19/x) core model.
module tb_reciprocal_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_data;
    logic        rsp_err;
    logic        core_start;
    logic [15:0] core_in;
    logic        core_ready;
    logic [23:0] core_out;
    logic        busy;

    logic        mdl_ready;
    logic [23:0] mdl_out;
    logic [15:0] mdl_x;
    int          mdl_cd;
    bit          core_dead;
    logic        inj_ready;
    logic [23:0] inj_out;
    int          start_cnt = 0;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n, sc;
    logic        stale;
    logic [23:0] rr_exp [4] = '{24'h080000, 24'h040000, 24'h020000, 24'h010000};

    always #5 clk = ~clk;

    reciprocal_arbiter #(.N_REQ(4), .IN_W(16), .OUT_W(24), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .core_start (core_start),
        .core_in    (core_in),
        .core_ready (core_ready),
        .core_out   (core_out),
        .busy       (busy)
    );

    // Core model: result strobe 5 cycles after core_start unless core_dead.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_ready <= 1'b0;
            mdl_out   <= '0;
            mdl_cd    <= 0;
        end else begin
            mdl_ready <= 1'b0;
            if (core_start) begin
                mdl_cd <= 4;
                mdl_x  <= core_in;
            end else if (mdl_cd > 0) begin
                mdl_cd <= mdl_cd - 1;
                if (mdl_cd == 1 && !core_dead) begin
                    mdl_ready <= 1'b1;
                    mdl_out   <= 24'((32'd1 << 19) / 32'(mdl_x));
                end
            end
        end
    end

    assign core_ready = mdl_ready | inj_ready;
    assign core_out   = inj_ready ? inj_out : mdl_out;

    always @(posedge clk) if (core_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_rsp(input string tag, input int start, input int limit, output int cnt);
        cnt = start;
        while (rsp_valid !== 1'b1 && cnt < limit) begin
            @(negedge clk); #1;
            cnt++;
        end
        if (rsp_valid !== 1'b1) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        inj_ready = 1'b0; inj_out = '0; core_dead = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_flags", {busy, core_start, rsp_valid, rsp_err, rsp_id, req_ready}, 32'd0);
        check("reset_data", {rsp_data, 8'd0}, 32'd0);
        check("reset_core_in", core_in, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Round-robin from reset: 0,1,2,3,0
        @(negedge clk);
        req_data  = {16'd8, 16'd4, 16'd2, 16'd1};
        req_valid = 4'hF;
        #1;
        for (int t = 0; t < 5; t++) begin
            check($sformatf("rr_grant%0d", t), req_ready, 4'b0001 << (t % 4));
            @(negedge clk); #1;
            check($sformatf("rr_issue_ready%0d", t), req_ready, 32'd0);
            wait_rsp("rr", 1, 20, n);
            check($sformatf("rr_id%0d", t), rsp_id, t % 4);
            check($sformatf("rr_data%0d", t), rsp_data, rr_exp[t % 4]);
            check($sformatf("rr_ready_in_resp%0d", t), req_ready, 32'd0);
            handshake();
        end
        req_valid = '0;

        // Single request, x=3
        @(negedge clk);
        req_data[15:0] = 16'd3;
        req_valid      = 4'b0001;
        #1;
        check("single_grant", req_ready, 32'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("single_start", core_start, 32'd1);
        check("single_core_in", core_in, 32'd3);
        wait_rsp("single", 1, 40, n);
        check("single_latency", n, 32'd7);
        check("single_data", rsp_data, 32'h02AAAA);
        check("single_id", rsp_id, 32'd0);
        check("single_err", rsp_err, 32'd0);
        handshake();
        check("single_idle", busy, 32'd0);

        // Zero operand on requester 2
        @(negedge clk);
        req_data[47:32] = 16'd0;
        req_valid       = 4'b0100;
        #1;
        check("zero_grant", req_ready, 32'b0100);
        sc = start_cnt;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("zero_rsp_valid", rsp_valid, 32'd1);
        check("zero_data", rsp_data, 32'hFFFFFF);
        check("zero_err", rsp_err, 32'd1);
        check("zero_id", rsp_id, 32'd2);
        handshake();
        check("zero_no_start", start_cnt - sc, 32'd0);

        // Watchdog timeout on requester 1
        core_dead = 1'b1;
        @(negedge clk);
        req_data[31:16] = 16'd7;
        req_valid       = 4'b0010;
        #1;
        check("to_grant", req_ready, 32'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_rsp("to", 1, 100, n);
        check("to_latency", n, 32'd66);
        check("to_data", rsp_data, 32'd0);
        check("to_err", rsp_err, 32'd1);
        check("to_id", rsp_id, 32'd1);
        repeat (10) @(negedge clk);
        inj_out   = 24'h123456;
        inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        #1;
        check("to_late_ignored", {rsp_valid, rsp_err, rsp_data}, {6'd0, 1'b1, 1'b1, 24'd0});
        handshake();
        inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        #1;
        check("to_idle_ignored", {busy, rsp_valid}, 32'd0);
        core_dead = 1'b0;

        // Backpressure on requester 3, x=5; requester 0 waits meanwhile
        @(negedge clk);
        req_data[63:48] = 16'd5;
        req_valid       = 4'b1000;
        #1;
        check("bp_grant", req_ready, 32'b1000);
        @(negedge clk);
        req_data[15:0] = 16'd16;
        req_valid      = 4'b0001;
        #1;
        check("bp_issue_ready", req_ready, 32'd0);
        wait_rsp("bp", 1, 40, n);
        for (int c = 0; c < 20; c++) begin
            check($sformatf("bp_hold%0d", c), {rsp_valid, rsp_id, rsp_data, req_ready},
                  {1'b0, 1'b1, 2'd3, 24'h019999, 4'b0000});
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_at_hs", req_ready, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("bp_ready_after_hs", req_ready, 32'b0001);

        // Reset while WAITing on requester 0's transaction
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rst_txn_started", core_start, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_flags", {busy, core_start, rsp_valid, rsp_err, rsp_id, req_ready}, 32'd0);
        check("rst_data", {rsp_data, core_in[7:0]}, 32'd0);
        check("rst_core_in", core_in, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            stale = stale | rsp_valid | busy;
        end
        check("rst_no_stale", stale, 32'd0);
        @(negedge clk);
        req_data[15:0]  = 16'd16;
        req_data[31:16] = 16'd2;
        req_valid       = 4'b0011;
        #1;
        check("rst_prio_grant", req_ready, 32'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_rsp("post_rst", 1, 40, n);
        check("post_rst_latency", n, 32'd7);
        check("post_rst_data", rsp_data, 32'h008000);
        check("post_rst_id", rsp_id, 32'd0);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
